xcorr_sample_src: RTL

Sample source that drives the x_corr input stream. Holds a length-deep reference frame (y) and a length-deep search frame (x) in local register arrays. On a start pulse it transmits every circular lag of x against y as (xi, xq, yi, yq) beats over the valid/ready handshake that x_corr consumes. It sits directly upstream of x_corr, between the capture/load logic and the correlator.

---
 rtl/xcorr_sample_src_pkg.sv | 15 +
 rtl/xcorr_sample_src_if.sv | 30 +++
 rtl/xcorr_sample_src_cplx_frame_ram.sv | 33 +++
 rtl/xcorr_sample_src.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/xcorr_sample_src_pkg.sv
// Shared types and defaults for the x_corr sample source.
// State encoding and frame/lag defaults used by the top and its users.
package xcorr_sample_src_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam int unsigned default_length   = 5;
    localparam int unsigned default_num_lags = 5;
    localparam int unsigned total_beats      = default_num_lags * default_length;

endpackage

// File: rtl/xcorr_sample_src_if.sv
// Beat stream between the sample source and x_corr.
// Payload, lag tag and tlast travel with the valid/ready pair.
interface xcorr_sample_src_if #(
    parameter int unsigned xi_bits  = 12,
    parameter int unsigned xq_bits  = 12,
    parameter int unsigned yi_bits  = 12,
    parameter int unsigned yq_bits  = 12,
    parameter int unsigned lag_bits = 3
);
    logic signed [xi_bits-1:0] xi;
    logic signed [xq_bits-1:0] xq;
    logic signed [yi_bits-1:0] yi;
    logic signed [yq_bits-1:0] yq;
    logic [lag_bits-1:0]       lag;
    logic                      m_axis_tvalid;
    logic                      m_axis_tlast;
    logic                      s_axis_tready;

    modport master (
        output xi, xq, yi, yq, lag,
        output m_axis_tvalid, m_axis_tlast,
        input  s_axis_tready
    );

    modport slave (
        input  xi, xq, yi, yq, lag,
        input  m_axis_tvalid, m_axis_tlast,
        output s_axis_tready
    );
endinterface

// File: rtl/xcorr_sample_src_cplx_frame_ram.sv
// Length-deep I/Q register array for one frame.
// Synchronous write, combinational read; contents have no reset.
module cplx_frame_ram
    import xcorr_sample_src_pkg::*;
#(
    parameter int unsigned depth     = default_length,
    parameter int unsigned addr_bits = 3,
    parameter int unsigned i_bits    = 12,
    parameter int unsigned q_bits    = 12
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [addr_bits-1:0]     wr_addr,
    input  logic signed [i_bits-1:0] wr_i,
    input  logic signed [q_bits-1:0] wr_q,
    input  logic [addr_bits-1:0]     rd_addr,
    output logic signed [i_bits-1:0] rd_i,
    output logic signed [q_bits-1:0] rd_q
);
    logic signed [i_bits-1:0] mem_i [depth];
    logic signed [q_bits-1:0] mem_q [depth];

    // Sample storage; the caller guarantees wr_addr is in range.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_i[wr_addr] <= wr_i;
            mem_q[wr_addr] <= wr_q;
        end
    end

    assign rd_i = mem_i[rd_addr];
    assign rd_q = mem_q[rd_addr];
endmodule

// File: rtl/xcorr_sample_src.sv
// Streams every circular lag of x against y as (xi,xq,yi,yq) beats.
// Frames load in IDLE; a start pulse emits num_lags*length beats.
module xcorr_sample_src
    import xcorr_sample_src_pkg::*;
#(
    parameter int unsigned xi_bits             = 12,
    parameter int unsigned xq_bits             = 12,
    parameter int unsigned yi_bits             = 12,
    parameter int unsigned yq_bits             = 12,
    parameter int unsigned length              = default_length,
    parameter int unsigned length_counter_bits = 3,
    parameter int unsigned num_lags            = default_num_lags,
    parameter int unsigned lag_bits            = 3
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 x_wr_en,
    input  logic [length_counter_bits-1:0]       x_wr_addr,
    input  logic signed [xi_bits-1:0]            x_wr_i,
    input  logic signed [xq_bits-1:0]            x_wr_q,
    input  logic                                 y_wr_en,
    input  logic [length_counter_bits-1:0]       y_wr_addr,
    input  logic signed [yi_bits-1:0]            y_wr_i,
    input  logic signed [yq_bits-1:0]            y_wr_q,
    input  logic                                 start,
    xcorr_sample_src_if.master                   axis,
    output logic                                 busy,
    output logic                                 done
);
    localparam int unsigned cb = length_counter_bits;

    localparam logic [cb-1:0]       last_k   = cb'(length - 1);
    localparam logic [lag_bits-1:0] last_lag = lag_bits'(num_lags - 1);
    localparam logic [cb:0]         len_ext  = (cb + 1)'(length);

    state_e state_q, state_d;

    logic [cb-1:0]       k_q, k_d;
    logic [lag_bits-1:0] lag_q, lag_d;
    logic                tvalid_q, tvalid_d;
    logic                tlast_q, tlast_d;
    logic                done_q, done_d;

    logic signed [xi_bits-1:0] xi_q, xi_d;
    logic signed [xq_bits-1:0] xq_q, xq_d;
    logic signed [yi_bits-1:0] yi_q, yi_d;
    logic signed [yq_bits-1:0] yq_q, yq_d;

    logic                x_we, y_we;
    logic                accept, final_beat;
    logic                load, clear;
    logic [cb-1:0]       nxt_k, rd_k, x_rd_addr;
    logic [lag_bits-1:0] nxt_lag, rd_lag;
    logic [cb:0]         x_sum;

    logic signed [xi_bits-1:0] x_ram_i, x_fwd_i;
    logic signed [xq_bits-1:0] x_ram_q, x_fwd_q;
    logic signed [yi_bits-1:0] y_ram_i, y_fwd_i;
    logic signed [yq_bits-1:0] y_ram_q, y_fwd_q;

    // Frames are writable only while idle and only inside the frame.
    assign x_we = x_wr_en && (state_q == ST_IDLE) && (x_wr_addr <= last_k);
    assign y_we = y_wr_en && (state_q == ST_IDLE) && (y_wr_addr <= last_k);

    assign accept     = tvalid_q && axis.s_axis_tready;
    assign final_beat = (lag_q == last_lag) && (k_q == last_k);

    cplx_frame_ram #(
        .depth     (length),
        .addr_bits (cb),
        .i_bits    (xi_bits),
        .q_bits    (xq_bits)
    ) u_x_ram (
        .clk     (clk),
        .wr_en   (x_we),
        .wr_addr (x_wr_addr),
        .wr_i    (x_wr_i),
        .wr_q    (x_wr_q),
        .rd_addr (x_rd_addr),
        .rd_i    (x_ram_i),
        .rd_q    (x_ram_q)
    );

    cplx_frame_ram #(
        .depth     (length),
        .addr_bits (cb),
        .i_bits    (yi_bits),
        .q_bits    (yq_bits)
    ) u_y_ram (
        .clk     (clk),
        .wr_en   (y_we),
        .wr_addr (y_wr_addr),
        .wr_i    (y_wr_i),
        .wr_q    (y_wr_q),
        .rd_addr (rd_k),
        .rd_i    (y_ram_i),
        .rd_q    (y_ram_q)
    );

    // Address of the beat to load next: (0,0) from idle, else the
    // successor of the beat on the bus; x index wraps by subtraction.
    always_comb begin
        nxt_k   = (k_q == last_k) ? '0 : k_q + cb'(1);
        nxt_lag = (k_q == last_k) ? lag_q + lag_bits'(1) : lag_q;
        rd_k    = (state_q == ST_IDLE) ? '0 : nxt_k;
        rd_lag  = (state_q == ST_IDLE) ? '0 : nxt_lag;
        x_sum   = {1'b0, rd_k} + (cb + 1)'(rd_lag);
        if (x_sum >= len_ext) begin
            x_rd_addr = cb'(x_sum - len_ext);
        end else begin
            x_rd_addr = cb'(x_sum);
        end
    end

    // A write landing on the same edge as start must reach beat (0,0).
    always_comb begin
        x_fwd_i = x_ram_i;
        x_fwd_q = x_ram_q;
        y_fwd_i = y_ram_i;
        y_fwd_q = y_ram_q;
        if (x_we && (x_wr_addr == x_rd_addr)) begin
            x_fwd_i = x_wr_i;
            x_fwd_q = x_wr_q;
        end
        if (y_we && (y_wr_addr == rd_k)) begin
            y_fwd_i = y_wr_i;
            y_fwd_q = y_wr_q;
        end
    end

    // Run sequencing plus output-register next values.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        lag_d    = lag_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        done_d   = 1'b0;
        xi_d     = xi_q;
        xq_d     = xq_q;
        yi_d     = yi_q;
        yq_d     = yq_q;
        load     = 1'b0;
        clear    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_STREAM;
                    load    = 1'b1;
                end
            end
            ST_STREAM: begin
                if (accept) begin
                    if (final_beat) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        clear   = 1'b1;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            k_d      = rd_k;
            lag_d    = rd_lag;
            tvalid_d = 1'b1;
            tlast_d  = (rd_k == last_k);
            xi_d     = x_fwd_i;
            xq_d     = x_fwd_q;
            yi_d     = y_fwd_i;
            yq_d     = y_fwd_q;
        end
        if (clear) begin
            k_d      = '0;
            lag_d    = '0;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            xi_d     = '0;
            xq_d     = '0;
            yi_d     = '0;
            yq_d     = '0;
        end
    end

    // State, counters and the beat register; reset aborts a run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            lag_q    <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            done_q   <= 1'b0;
            xi_q     <= '0;
            xq_q     <= '0;
            yi_q     <= '0;
            yq_q     <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            lag_q    <= lag_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            done_q   <= done_d;
            xi_q     <= xi_d;
            xq_q     <= xq_d;
            yi_q     <= yi_d;
            yq_q     <= yq_d;
        end
    end

    assign axis.xi            = xi_q;
    assign axis.xq            = xq_q;
    assign axis.yi            = yi_q;
    assign axis.yq            = yq_q;
    assign axis.lag           = lag_q;
    assign axis.m_axis_tvalid = tvalid_q;
    assign axis.m_axis_tlast  = tlast_q;

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
endmodule
